// File: rtl/dmem_arbiter.sv
// Two-port (cpu/dma) arbiter in front of the single-port 128-word data SRAM.
// Default: CPU priority with a DMA starvation guard; define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data2Mem,
  input  logic [DATA_W-1:0] ReadDataMem
);

  logic              acc_p0;
  logic              we_p0;
  logic              own_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              vld_p1;
  logic              own_p1;
  logic              vld_p2;
  logic              own_p2;

`ifdef DMEM_ARB_RR_EN
  // last_owner: 0 = cpu, 1 = dma; on contention the other port wins
  logic last_owner;

  always_comb begin
    cpu_gnt = cpu_req && (!dma_req || last_owner);
    dma_gnt = dma_req && (!cpu_req || !last_owner);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= 1'b0;
    end else if (cpu_gnt) begin
      last_owner <= 1'b0;
    end else if (dma_gnt) begin
      last_owner <= 1'b1;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             prio_dma;

  always_comb begin
    prio_dma = (starve_cnt == CNT_W'(STARVE_MAX));
    cpu_gnt  = cpu_req && !(dma_req && prio_dma);
    dma_gnt  = dma_req && (!cpu_req || prio_dma);
  end

  // Counts denied DMA cycles; saturates so the guard stays armed until DMA wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (dma_gnt) begin
      starve_cnt <= '0;
    end else if (dma_req && !prio_dma) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`endif

  // Stage p0: select the granted port's command
  always_comb begin
    acc_p0   = cpu_gnt || dma_gnt;
    own_p0   = dma_gnt;
    we_p0    = dma_gnt ? dma_we    : cpu_we;
    addr_p0  = dma_gnt ? dma_addr  : cpu_addr;
    wdata_p0 = dma_gnt ? dma_wdata : cpu_wdata;
  end

  // Stage p1: registered SRAM command; A/Data2Mem hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CEN      <= 1'b1;
      WEN      <= 1'b1;
      OEN      <= 1'b1;
      A        <= '0;
      Data2Mem <= '0;
    end else if (acc_p0) begin
      CEN      <= 1'b0;
      WEN      <= ~we_p0;
      OEN      <= we_p0;
      A        <= addr_p0;
      Data2Mem <= wdata_p0;
    end else begin
      CEN      <= 1'b1;
      WEN      <= 1'b1;
      OEN      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      own_p1 <= 1'b0;
    end else begin
      vld_p1 <= acc_p0 && !we_p0;
      own_p1 <= own_p0;
    end
  end

  // Stage p2: tag lines up with ReadDataMem from the SRAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      own_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      own_p2 <= own_p1;
    end
  end

  always_comb begin
    cpu_rvalid = vld_p2 && !own_p2;
    dma_rvalid = vld_p2 && own_p2;
    cpu_rdata  = ReadDataMem;
    dma_rdata  = ReadDataMem;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table for grants/command register, scoreboard for read returns.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [6:0]  cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem, ReadDataMem;

  dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
    .ReadDataMem(ReadDataMem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: samples the registered command at the edge, read data valid the next cycle
  logic [31:0] mem [0:127];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= Data2Mem;
      else if (!OEN) rd_q <= mem[A];
    end
  end
  assign ReadDataMem = rd_q;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [6:0]  ca;
    logic [31:0] cd;
    logic [6:0]  da;
    logic [31:0] dd;
    logic [1:0]  eg;
  } vec_t;

  typedef struct {
    logic        own;
    logic [31:0] data;
    int          due;
  } rsp_t;

  vec_t        tbl[$];
  rsp_t        sb[$];
  rsp_t        mon_r;
  logic [31:0] ref_mem [0:127];
  logic [2:0]  e_cmd;
  logic [6:0]  e_a;
  logic [31:0] e_d;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] we,
                              input logic [6:0] ca, input logic [31:0] cd,
                              input logic [6:0] da, input logic [31:0] dd,
                              input logic [1:0] eg);
    vec_t v;
    v.req = req; v.we = we; v.ca = ca; v.cd = cd;
    v.da = da; v.dd = dd; v.eg = eg;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(2'b00, 2'b00, 7'h00, 32'h0, 7'h00, 32'h0, 2'b00);
  endfunction

  task automatic step(input vec_t v);
    logic        we;
    logic [6:0]  ad;
    logic [31:0] wd;
    @(negedge clk);
    chk("cmd", 64'({CEN, WEN, OEN}), 64'(e_cmd));
    chk("addr", 64'(A), 64'(e_a));
    chk("wdata", 64'(Data2Mem), 64'(e_d));
    {cpu_req, dma_req} = v.req;
    {cpu_we, dma_we}   = v.we;
    cpu_addr = v.ca; cpu_wdata = v.cd;
    dma_addr = v.da; dma_wdata = v.dd;
    #1;
    chk("gnt", 64'({cpu_gnt, dma_gnt}), 64'(v.eg));
    if (v.eg != 2'b00) begin
      if (v.eg[1]) begin we = v.we[1]; ad = v.ca; wd = v.cd; end
      else         begin we = v.we[0]; ad = v.da; wd = v.dd; end
      e_cmd = {1'b0, ~we, we};
      e_a   = ad;
      e_d   = wd;
      if (we) ref_mem[ad] = wd;
      else    sb.push_back('{own: ~v.eg[1], data: ref_mem[ad], due: cyc + 2});
    end else begin
      e_cmd = 3'b111;
    end
  endtask

  always @(negedge clk) begin
    if (cpu_rvalid || dma_rvalid) begin
      if (cpu_rvalid && dma_rvalid) begin
        checks++; errors++;
        $display("FAIL rvalid_both: got cpu=1 dma=1 required one-hot (cycle %0d)", cyc);
      end else if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got rvalid cpu=%0b dma=%0b required none (cycle %0d)",
                 cpu_rvalid, dma_rvalid, cyc);
      end else begin
        mon_r = sb.pop_front();
        chk("rsp_owner", 64'(dma_rvalid), 64'(mon_r.own));
        chk("rsp_data", 64'(cpu_rvalid ? cpu_rdata : dma_rdata), 64'(mon_r.data));
        chk("rsp_cycle", 64'(cyc), 64'(mon_r.due));
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      mon_r = sb.pop_front();
      checks++; errors++;
      $display("FAIL rsp_missing: got no rvalid required at cycle %0d (now %0d)", mon_r.due, cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish required by 100000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    {cpu_req, cpu_we, dma_req, dma_we} = 4'b0;
    cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0;
    e_cmd = 3'b111; e_a = '0; e_d = '0;

    // basic cpu/dma traffic, no contention
    tbl.push_back(idle());
    tbl.push_back(mk(2'b10, 2'b10, 7'h05, 32'hDEADBEEF, 7'h00, 32'h0, 2'b10));
    tbl.push_back(idle());
    tbl.push_back(mk(2'b10, 2'b00, 7'h05, 32'h0, 7'h00, 32'h0, 2'b10));
    tbl.push_back(mk(2'b10, 2'b10, 7'h01, 32'h11111111, 7'h00, 32'h0, 2'b10));
    tbl.push_back(mk(2'b10, 2'b10, 7'h02, 32'h22222222, 7'h00, 32'h0, 2'b10));
    tbl.push_back(mk(2'b10, 2'b10, 7'h03, 32'h33333333, 7'h00, 32'h0, 2'b10));
    tbl.push_back(mk(2'b10, 2'b00, 7'h01, 32'h0, 7'h00, 32'h0, 2'b10));
    tbl.push_back(mk(2'b10, 2'b00, 7'h02, 32'h0, 7'h00, 32'h0, 2'b10));
    tbl.push_back(mk(2'b10, 2'b00, 7'h03, 32'h0, 7'h00, 32'h0, 2'b10));
    tbl.push_back(mk(2'b01, 2'b01, 7'h00, 32'h0, 7'h0A, 32'hA5A5A5A5, 2'b01));
    tbl.push_back(mk(2'b01, 2'b00, 7'h00, 32'h0, 7'h0A, 32'h0, 2'b01));
    tbl.push_back(idle());
`ifdef DMEM_ARB_RR_EN
    tbl.push_back(mk(2'b11, 2'b00, 7'h01, 32'h0, 7'h0A, 32'h0, 2'b10));
    tbl.push_back(mk(2'b11, 2'b00, 7'h02, 32'h0, 7'h0A, 32'h0, 2'b01));
    tbl.push_back(mk(2'b11, 2'b01, 7'h02, 32'h0, 7'h14, 32'h55555555, 2'b10));
    tbl.push_back(mk(2'b11, 2'b11, 7'h04, 32'h44444444, 7'h14, 32'h55555555, 2'b01));
    tbl.push_back(mk(2'b11, 2'b10, 7'h04, 32'h44444444, 7'h14, 32'h0, 2'b10));
    tbl.push_back(mk(2'b11, 2'b00, 7'h04, 32'h0, 7'h14, 32'h0, 2'b01));
    tbl.push_back(mk(2'b10, 2'b00, 7'h04, 32'h0, 7'h00, 32'h0, 2'b10));
`else
    // both requesting: four cpu grants then the starvation guard hands one to dma
    tbl.push_back(mk(2'b11, 2'b00, 7'h01, 32'h0, 7'h0A, 32'h0, 2'b10));
    tbl.push_back(mk(2'b11, 2'b00, 7'h02, 32'h0, 7'h0A, 32'h0, 2'b10));
    tbl.push_back(mk(2'b11, 2'b10, 7'h04, 32'h44444444, 7'h0A, 32'h0, 2'b10));
    tbl.push_back(mk(2'b11, 2'b00, 7'h04, 32'h0, 7'h0A, 32'h0, 2'b10));
    tbl.push_back(mk(2'b11, 2'b00, 7'h03, 32'h0, 7'h0A, 32'h0, 2'b01));
    tbl.push_back(mk(2'b11, 2'b01, 7'h03, 32'h0, 7'h14, 32'h55555555, 2'b10));
    tbl.push_back(mk(2'b11, 2'b11, 7'h15, 32'h66666666, 7'h14, 32'h55555555, 2'b10));
    tbl.push_back(mk(2'b11, 2'b01, 7'h15, 32'h0, 7'h14, 32'h55555555, 2'b10));
    tbl.push_back(mk(2'b11, 2'b01, 7'h05, 32'h0, 7'h14, 32'h55555555, 2'b10));
    tbl.push_back(mk(2'b11, 2'b01, 7'h05, 32'h0, 7'h14, 32'h55555555, 2'b01));
    tbl.push_back(mk(2'b11, 2'b00, 7'h05, 32'h0, 7'h14, 32'h0, 2'b10));
    tbl.push_back(mk(2'b01, 2'b00, 7'h00, 32'h0, 7'h14, 32'h0, 2'b01));
`endif
    tbl.push_back(mk(2'b10, 2'b10, 7'h7F, 32'hFFFFFFFF, 7'h00, 32'h0, 2'b10));
    tbl.push_back(mk(2'b01, 2'b00, 7'h00, 32'h0, 7'h7F, 32'h0, 2'b01));
    tbl.push_back(idle());
    tbl.push_back(idle());
    tbl.push_back(idle());

    // reset held three cycles with no requests
    repeat (3) begin
      @(negedge clk);
      chk("rst_cmd", 64'({CEN, WEN, OEN}), 64'(3'b111));
      chk("rst_addr", 64'(A), 64'h0);
      chk("rst_wdata", 64'(Data2Mem), 64'h0);
      chk("rst_gnt_rvalid", 64'({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid}), 64'h0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // dma read accepted, then reset pulsed before its data returns
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 7'h05;
    #1 chk("midrst_gnt", 64'({cpu_gnt, dma_gnt}), 64'(2'b01));
    @(negedge clk);
    dma_req = 1'b0;
    chk("midrst_cmd_pre", 64'({CEN, WEN, OEN}), 64'(3'b010));
    chk("midrst_addr_pre", 64'(A), 64'h05);
    #1 rst_n = 1'b0;
    #1 chk("midrst_cmd", 64'({CEN, WEN, OEN}), 64'(3'b111));
    chk("midrst_addr", 64'(A), 64'h0);
    chk("midrst_wdata", 64'(Data2Mem), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    e_cmd = 3'b111; e_a = '0; e_d = '0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_rvalid", 64'({cpu_rvalid, dma_rvalid}), 64'h0);
    end

    // contention straight after reset
`ifdef DMEM_ARB_RR_EN
    step(mk(2'b11, 2'b00, 7'h05, 32'h0, 7'h7F, 32'h0, 2'b01));
    step(mk(2'b10, 2'b00, 7'h05, 32'h0, 7'h00, 32'h0, 2'b10));
`else
    step(mk(2'b11, 2'b00, 7'h05, 32'h0, 7'h7F, 32'h0, 2'b10));
    step(mk(2'b01, 2'b00, 7'h00, 32'h0, 7'h7F, 32'h0, 2'b01));
`endif
    repeat (4) step(idle());

    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 128-word data SRAM (active-low CEN/WEN/OEN, 7-bit word address) between two requesters: the processor load/store port (cpu) and a loader/debug DMA port (dma).
- Arbitrates one access per cycle, registers the SRAM command signals and routes read data back to the requester that issued the read.
- Default policy is CPU priority, with a starvation guard that forces a DMA grant.
- Sits between the core's memory interface and the SRAM macro.

Parameters:
ADDR_W, 7, word address width (A port)
DATA_W, 32, data width
STARVE_MAX, 4, number of consecutive denied DMA cycles before DMA gets priority; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU word address
cpu_wdata  input  DATA_W  CPU write data
cpu_gnt  output  1  CPU request accepted this cycle (combinational)
cpu_rvalid  output  1  CPU read data valid
cpu_rdata  output  DATA_W  CPU read data
dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_W/DATA_W  same meaning as the CPU port, for DMA
dma_gnt  output  1  DMA request accepted this cycle (combinational)
dma_rvalid  output  1  DMA read data valid
dma_rdata  output  DATA_W  DMA read data
CEN  output  1  SRAM chip enable, active low, registered
WEN  output  1  SRAM write enable, active low, registered
OEN  output  1  SRAM output enable, active low, registered
A  output  ADDR_W  SRAM address, registered
Data2Mem  output  DATA_W  SRAM write data, registered
ReadDataMem  input  DATA_W  SRAM read data

Behaviour:
- Reset:
  - Clock and reset are `clk` and `rst_n`; reset is asynchronous and active-low.
  - While rst_n=0: CEN=WEN=OEN=1, A=0, Data2Mem=0, starve_cnt=0, read-tag pipeline cleared, cpu_rvalid=dma_rvalid=0.
  - Asserting reset mid-operation drops any pending read response; it is never delivered.
- Handshake:
  - An access is accepted in a cycle where req && gnt.
  - A requester holds req, we, addr and wdata stable until granted.
  - Back-to-back accepts in consecutive cycles are allowed.
- Grant (fixed-priority mode):
  - prio_dma = (starve_cnt == STARVE_MAX).
  - cpu_gnt = cpu_req && !(dma_req && prio_dma).
  - dma_gnt = dma_req && (!cpu_req || prio_dma).
  - At most one grant per cycle.
- Starvation counter:
  - Each edge: if dma_gnt, reset to 0.
  - Else if dma_req, increment, saturating at STARVE_MAX.
  - Else hold.
- Command register, at the edge ending accept cycle t:
  - CEN<=0, WEN<=~we, OEN<=we (low only for reads), A<=addr, Data2Mem<=wdata of the granted port.
  - No accept: CEN<=1, WEN<=1, OEN<=1; A and Data2Mem hold.
- SRAM timing: the SRAM samples the command at the end of cycle t+1; ReadDataMem is valid during cycle t+2.
- Read return:
  - A 2-stage tag pipeline carries {valid, owner}; owner is registered at accept.
  - In cycle t+2 the owner's rvalid=1 for exactly one cycle, and its rdata = ReadDataMem (combinational pass-through).
  - The other port's rvalid=0.
  - rdata is don't-care when rvalid=0.
  - Read latency is 2 cycles from accept; writes produce no response.
- Ordering: responses return in accept order; a read after a write to the same address returns the new data, because the SRAM processes accesses in order.
- Simultaneous events: dma_gnt in the same cycle the counter saturates is impossible, because the counter only reaches STARVE_MAX on a denial edge.

Optional Feature:
- DMEM_ARB_RR_EN defined:
  - Round-robin arbitration. A last_owner flop resets to cpu and updates on each accept.
  - On contention, the port that is not last_owner is granted; a single requester is always granted.
  - starve_cnt and STARVE_MAX are unused.
- Not defined: fixed CPU priority with the starvation guard, as above.

Test Plan:
- Reset with no requests -> CEN=WEN=OEN=1, A=0, all gnt/rvalid 0; hold rst_n=0 for 3 cycles, outputs unchanged.
- CPU write addr 0x05 data 0xDEADBEEF accepted in cycle t -> cycle t+1: CEN=0, WEN=0, OEN=1, A=0x05, Data2Mem=0xDEADBEEF. Then a CPU read of 0x05 accepted in cycle u -> cpu_rvalid=1, cpu_rdata=0xDEADBEEF in cycle u+2, dma_rvalid=0.
- STARVE_MAX=4, cpu_req and dma_req both held high -> grants cpu,cpu,cpu,cpu,dma repeating (4:1); starve_cnt returns to 0 after each DMA grant.
- CPU reads addr 1,2,3 accepted in consecutive cycles t..t+2 -> cpu_rvalid high in cycles t+2..t+4, with data of addr 1,2,3 in that order.
- DMA read accepted in cycle t, rst_n pulsed low in cycle t+1 -> CEN/OEN return to 1 immediately; dma_rvalid never asserts.
- With DMEM_ARB_RR_EN, both ports requesting continuously -> grants alternate cpu,dma,cpu,dma starting with dma after reset (last_owner=cpu).
